fifo_wr_arb_ctrl: RTL
=====================

// Module: fifo_wr_arb_ctrl
// PURPOSE
//   Controller for the single-port-write / single-port-read FIFO buffer. Arbitrates
//   two producers (round-robin) onto the one write port, owns the write/read
//   pointer counters, occupancy count and full/empty flags, and drives the RAM
//   write/read enables and addresses. Sits between the producers, the FIFO RAM and the consumer.
// PARAMETERS
//   ADDR_W     5    address width; DEPTH = 2**ADDR_W entries (32 by default)
//   AF_LEVEL   28   almost_full threshold, count >= AF_LEVEL (only with FIFO_CTRL_ALMOST_EN)
//   AE_LEVEL   4    almost_empty threshold, count <= AE_LEVEL (only with FIFO_CTRL_ALMOST_EN)
// PORTS
//   CLK          in   1         clock, all state on rising edge
//   reset        in   1         synchronous, active-high reset
//   req0         in   1         producer 0 write request
//   req1         in   1         producer 1 write request
//   gnt0         out  1         producer 0 granted; write accepted this cycle
//   gnt1         out  1         producer 1 granted; write accepted this cycle
//   wr_en        out  1         RAM write enable (= gnt0 | gnt1)
//   wr_sel       out  1         RAM write-data mux select: 0 = producer 0, 1 = producer 1
//   wr_addr      out  ADDR_W    RAM write address (write pointer)
//   rd_req       in   1         consumer read request
//   rd_en        out  1         RAM read enable; read accepted this cycle
//   rd_addr      out  ADDR_W    RAM read address (read pointer)
//   count        out  ADDR_W+1  occupancy, 0..DEPTH
//   full         out  1         count == DEPTH
//   empty        out  1         count == 0
//   ovf          out  1         sticky: write requested while full
//   udf          out  1         sticky: read requested while empty
// BEHAVIOUR
//   - Reset (CLK edge with reset=1): wr_addr=0, rd_addr=0, count=0, empty=1, full=0,
//     ovf=0, udf=0, last=1 (producer 0 wins first contention). Reset overrides all
//     same-cycle requests; an in-flight write/read that cycle is discarded.
//   - Grants are combinational from req0/req1, last and full, and are 0 while reset=1.
//     full=1 -> gnt0=gnt1=0. Exactly one request -> that producer granted.
//     Both requesting -> grant the producer != last. Never both grants at once.
//   - last <= index of granted producer on every accepted write; otherwise held.
//   - wr_sel = gnt1. wr_addr advances by 1 on wr_en, wraps DEPTH-1 -> 0.
//   - rd_en = rd_req & ~empty (combinational). rd_addr advances by 1 on rd_en, wraps
//     DEPTH-1 -> 0. Read data valid at RAM output the cycle after rd_en.
//   - count: +1 on wr_en only, -1 on rd_en only, unchanged on both or neither.
//     full/empty registered and consistent with count in the same cycle.
//   - Full + read + write requests same cycle: write blocked (full checked on current
//     state), read proceeds -> count = DEPTH-1 next cycle.
//   - Empty + read + write same cycle: read blocked, write proceeds -> count = 1.
//   - ovf <= 1 if (req0|req1) & full; udf <= 1 if rd_req & empty; cleared only by reset.
//   - Latency: write accepted same cycle as grant; entry readable the cycle after.
// CONFIGURATION
//   FIFO_CTRL_ALMOST_EN defined: adds outputs almost_full (1 bit, count >= AF_LEVEL) and
//     almost_empty (1 bit, count <= AE_LEVEL), registered, reset to 0 and 1.
//   Not defined: those ports and their logic do not exist; AF_LEVEL/AE_LEVEL unused.
// TESTING
//   1 reset=1 for 2 cycles with all requests high -> no grants, count=0, empty=1, ovf=udf=0.
//   2 req0=1 only for 32 cycles -> gnt0 every cycle, wr_addr 0..31 then 0, full=1 at count=32;
//     req0 held 1 more cycle -> gnt0=0, ovf=1.
//   3 req0=req1=1 continuously from empty -> grants alternate gnt0,gnt1,gnt0,...; wr_sel 0,1,0.
//   4 fill to 32, then rd_req=req1=1 same cycle -> rd_en=1, gnt1=0, count=31;
//     next cycle -> both accepted, count stays 31.
//   5 empty, rd_req=1 + req0=1 -> rd_en=0, udf=1, count=1; then 40 reads of 1 write each
//     cycle -> rd_addr and wr_addr both wrap past 31, count stays 1.
//   6 FIFO_CTRL_ALMOST_EN defined, write 28 entries -> almost_full=1 at count=28,
//     almost_empty=0 from count=5; read back to 4 -> almost_empty=1.

Source files
------------

// File: rtl/fifo_wr_arb_ctrl.sv
// fifo_wr_arb_ctrl
//   Controller for a FIFO with one write port and one read port. Two
//   producers share the write port under round-robin arbitration. The block
//   owns the write and read pointers, the occupancy count, the full/empty
//   flags and the sticky overflow/underflow flags. It drives the RAM enables
//   and addresses.
//
// Ports
//   CLK, reset        clock; synchronous active-high reset
//   req0, req1        producer write requests
//   gnt0, gnt1        producer grants (the write is accepted this cycle)
//   wr_en, wr_sel     RAM write enable and write-data mux select (1 = producer 1)
//   wr_addr           RAM write address
//   rd_req            consumer read request
//   rd_en, rd_addr    RAM read enable and read address (data valid next cycle)
//   count             occupancy, 0..DEPTH
//   full, empty       registered occupancy flags
//   ovf, udf          sticky: write requested while full / read requested while empty
//   almost_full       count >= AF_LEVEL   (only with FIFO_CTRL_ALMOST_EN)
//   almost_empty      count <= AE_LEVEL   (only with FIFO_CTRL_ALMOST_EN)
//
// Optional feature macro: FIFO_CTRL_ALMOST_EN adds the almost_full and
// almost_empty outputs.

module fifo_wr_arb_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int AF_LEVEL = 28,
  parameter int AE_LEVEL = 4
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              rd_req,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  output logic              udf
`ifdef FIFO_CTRL_ALMOST_EN
  ,
  output logic              almost_full,
  output logic              almost_empty
`endif
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(2**ADDR_W);

  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [ADDR_W-1:0] rdAddr_q, rdAddr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              last_q, last_d;
  logic              gnt0C, gnt1C, rdEnC;

`ifdef FIFO_CTRL_ALMOST_EN
  localparam logic [ADDR_W:0] AF_C = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C = (ADDR_W+1)'(AE_LEVEL);
  logic almostFull_q, almostFull_d;
  logic almostEmpty_q, almostEmpty_d;
`endif

  // Arbitration uses only the current registered state. A full FIFO blocks
  // both producers even if a read drains an entry in the same cycle. When both
  // producers request, the grant goes to the producer that did not win last.
  // Reset suppresses all grants and reads so no access is accepted.
  always_comb begin
    gnt0C = 1'b0;
    gnt1C = 1'b0;
    if (!reset && !full_q) begin
      if (req0 && req1) begin
        if (last_q) gnt0C = 1'b1;
        else        gnt1C = 1'b1;
      end else if (req0) begin
        gnt0C = 1'b1;
      end else if (req1) begin
        gnt1C = 1'b1;
      end
    end
    rdEnC = rd_req & ~empty_q & ~reset;
  end

  // Next-state logic. A write and a read in the same cycle leave the count
  // unchanged. The flags are derived from the next count, so they stay in
  // step with count.
  always_comb begin
    wrAddr_d = wrAddr_q;
    rdAddr_d = rdAddr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (gnt0C || gnt1C) begin
      wrAddr_d = wrAddr_q + 1'b1;
      last_d   = gnt1C;
    end
    if (rdEnC) rdAddr_d = rdAddr_q + 1'b1;
    case ({gnt0C | gnt1C, rdEnC})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    ovf_d   = ovf_q | ((req0 | req1) & full_q);
    udf_d   = udf_q | (rd_req & empty_q);
`ifdef FIFO_CTRL_ALMOST_EN
    almostFull_d  = (count_d >= AF_C);
    almostEmpty_d = (count_d <= AE_C);
`endif
  end

  // last resets to 1 so that producer 0 wins the first contention.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wrAddr_q <= '0;
      rdAddr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      last_q   <= 1'b1;
`ifdef FIFO_CTRL_ALMOST_EN
      almostFull_q  <= 1'b0;
      almostEmpty_q <= 1'b1;
`endif
    end else begin
      wrAddr_q <= wrAddr_d;
      rdAddr_q <= rdAddr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      last_q   <= last_d;
`ifdef FIFO_CTRL_ALMOST_EN
      almostFull_q  <= almostFull_d;
      almostEmpty_q <= almostEmpty_d;
`endif
    end
  end

  assign gnt0    = gnt0C;
  assign gnt1    = gnt1C;
  assign wr_en   = gnt0C | gnt1C;
  assign wr_sel  = gnt1C;
  assign wr_addr = wrAddr_q;
  assign rd_en   = rdEnC;
  assign rd_addr = rdAddr_q;
  assign count   = count_q;
  assign full    = full_q;
  assign empty   = empty_q;
  assign ovf     = ovf_q;
  assign udf     = udf_q;
`ifdef FIFO_CTRL_ALMOST_EN
  assign almost_full  = almostFull_q;
  assign almost_empty = almostEmpty_q;
`endif

endmodule
